// File: rtl/task_dispatch_if.sv
`default_nettype none
// ------------------------------------------------------------------
// task_dispatch_if : request/ack/start/done bundle between the task
//                    register, the dispatcher and the task engines.
// Revision         : 1.0
// ------------------------------------------------------------------
interface task_dispatch_if #(
   parameter int P_NTASK = 16
);
   logic [P_NTASK-1:0] req;
   logic [P_NTASK-1:0] ack;
   logic [P_NTASK-1:0] task_go;
   logic [P_NTASK-1:0] task_done;
   logic               busy;
   logic [3:0]         cur_task;
   logic               err;

   modport master (
      output req, task_done,
      input  ack, task_go, busy, cur_task, err
   );

   modport slave (
      input  req, task_done,
      output ack, task_go, busy, cur_task, err
   );
endinterface
`default_nettype wire

// File: rtl/task_dispatch.sv
`default_nettype none
// ------------------------------------------------------------------
// task_dispatch : fixed-priority (lowest index first) single-flight
//                 dispatcher with four-phase per-task acknowledge.
//                 Optional RUN watchdog: TASK_DISPATCH_TIMEOUT_EN.
// Revision      : 1.0
// ------------------------------------------------------------------
module task_dispatch #(
   parameter int P_NTASK   = 16,
   parameter int P_TIMEOUT = 65535
) (
   input  wire logic       clk,
   input  wire logic       rst,
   task_dispatch_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GO   = 2'd1,
      S_RUN  = 2'd2,
      S_ACK  = 2'd3
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [P_NTASK-1:0] r_ack, w_ack_nxt;
   logic [P_NTASK-1:0] r_go, w_go_nxt;
   logic               r_busy, w_busy_nxt;
   logic [3:0]         r_cur, w_cur_nxt;
   logic [P_NTASK-1:0] w_cur_onehot;

   assign w_cur_onehot = {{(P_NTASK-1){1'b0}}, 1'b1} << r_cur;

`ifdef TASK_DISPATCH_TIMEOUT_EN
   logic        r_err, w_err_nxt;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic        w_timeout;
   assign w_timeout = (r_cnt == 16'(P_TIMEOUT));
`else
   logic [15:0] w_unused_timeout;
   assign w_unused_timeout = 16'(P_TIMEOUT);
`endif

   function automatic logic [3:0] f_lowest(input logic [P_NTASK-1:0] v);
      f_lowest = '0;
      for (int i = P_NTASK - 1; i >= 0; i--) begin
         if (v[i]) f_lowest = 4'(i);
      end
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = r_ack;
      w_go_nxt    = '0;
      w_busy_nxt  = r_busy;
      w_cur_nxt   = r_cur;
`ifdef TASK_DISPATCH_TIMEOUT_EN
      w_err_nxt   = r_err;
      w_cnt_nxt   = r_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (bus.req != '0) begin
               w_state_nxt = S_GO;
               w_cur_nxt   = f_lowest(bus.req);
               w_busy_nxt  = 1'b1;
            end
         end
         S_GO: begin
            w_go_nxt    = w_cur_onehot;
            w_state_nxt = S_RUN;
`ifdef TASK_DISPATCH_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
         end
         S_RUN: begin
            // Only the granted task's done line can complete the run.
            if (bus.task_done[r_cur]) begin
               w_state_nxt = S_ACK;
               w_ack_nxt   = w_cur_onehot;
            end
`ifdef TASK_DISPATCH_TIMEOUT_EN
            else if (w_timeout) begin
               w_state_nxt = S_ACK;
               w_ack_nxt   = w_cur_onehot;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + 16'd1;
            end
`endif
         end
         S_ACK: begin
            if (!bus.req[r_cur]) begin
               w_state_nxt = S_IDLE;
               w_ack_nxt   = '0;
               w_busy_nxt  = 1'b0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ack   <= '0;
         r_go    <= '0;
         r_busy  <= 1'b0;
         r_cur   <= '0;
`ifdef TASK_DISPATCH_TIMEOUT_EN
         r_err   <= 1'b0;
         r_cnt   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
         r_go    <= w_go_nxt;
         r_busy  <= w_busy_nxt;
         r_cur   <= w_cur_nxt;
`ifdef TASK_DISPATCH_TIMEOUT_EN
         r_err   <= w_err_nxt;
         r_cnt   <= w_cnt_nxt;
`endif
      end
   end

   assign bus.ack      = r_ack;
   assign bus.task_go  = r_go;
   assign bus.busy     = r_busy;
   assign bus.cur_task = r_cur;
`ifdef TASK_DISPATCH_TIMEOUT_EN
   assign bus.err      = r_err;
`else
   assign bus.err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_task_dispatch.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_task_dispatch : self-checking bench for task_dispatch with an
//                    auto-responding engine and ordering model.
// Revision         : 1.0
// ------------------------------------------------------------------
module tb_task_dispatch;

`ifdef TASK_DISPATCH_TIMEOUT_EN
   localparam int c_TIMEOUT = 20;
`else
   localparam int c_TIMEOUT = 65535;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   task_dispatch_if #(.P_NTASK(16)) bus ();

   task_dispatch #(.P_NTASK(16), .P_TIMEOUT(c_TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic        engine_auto  = 1'b0;
   int          engine_delay = 1;
   logic [15:0] auto_done    = '0;
   logic [15:0] man_done     = '0;
   logic [15:0] eng_g;
   assign bus.task_done = engine_auto ? auto_done : man_done;

   int          go_q[$];
   int          ack_q[$];
   int          n_multi_go  = 0;
   int          n_multi_ack = 0;
   logic [15:0] prev_ack    = '0;

   function automatic int f_idx(input logic [15:0] v);
      f_idx = -1;
      for (int i = 15; i >= 0; i--) if (v[i]) f_idx = i;
   endfunction

   // Observed go pulses and ack rising edges, in order.
   always @(negedge clk) begin
      if (bus.task_go != '0) begin
         go_q.push_back(f_idx(bus.task_go));
         if ($countones(bus.task_go) != 1) n_multi_go++;
      end
      if (bus.ack != '0 && prev_ack == '0) ack_q.push_back(f_idx(bus.ack));
      if ($countones(bus.ack) > 1) n_multi_ack++;
      prev_ack = bus.ack;
   end

   initial begin : engine
      forever begin
         @(negedge clk);
         if (engine_auto && bus.task_go != '0) begin
            eng_g = bus.task_go;
            repeat (engine_delay - 1) @(negedge clk);
            auto_done = eng_g;
            @(negedge clk);
            auto_done = '0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drops each request once acked (and optionally at its go pulse) until idle.
   task automatic service(input int bound, input bit early, output bit ok);
      int n;
      n  = 0;
      ok = 1'b1;
      while (bus.req != '0 || bus.busy || bus.ack != '0) begin
         @(negedge clk);
         n++;
         if (bus.ack != '0) bus.req = bus.req & ~bus.ack;
         if (early && bus.task_go != '0) bus.req = bus.req & ~bus.task_go;
         if (n > bound) begin
            ok = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 10; c++) begin
         bus.req = 16'($urandom_range(1, 65535));
         tick(1);
         total++;
         if ({bus.ack, bus.task_go, bus.busy, bus.cur_task, bus.err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ack=%h go=%h busy=%b cur=%0d err=%b want all 0",
                     bus.ack, bus.task_go, bus.busy, bus.cur_task, bus.err);
         end
      end
      bus.req = '0;
      rst     = 1'b0;
      tick(2);
      total++;
      if (go_q.size() != 0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_go: got pulses=%0d busy=%b want 0 0", go_q.size(), bus.busy);
      end
   endtask

   task automatic test_single();
      int go_base, ack_base;
      go_base  = go_q.size();
      ack_base = ack_q.size();
      engine_auto = 1'b0;
      bus.req = 16'h0004;
      tick(1);
      total++;
      if (bus.busy !== 1'b1 || bus.cur_task !== 4'd2 || bus.task_go !== '0) begin
         bad++;
         $display("FAIL single_grant: got busy=%b cur=%0d go=%h want 1 2 0000",
                  bus.busy, bus.cur_task, bus.task_go);
      end
      man_done = 16'h0004;   // during GO: must be ignored
      tick(1);
      total++;
      if (bus.task_go !== 16'h0004) begin
         bad++;
         $display("FAIL single_go: got %h want 0004", bus.task_go);
      end
      man_done = '0;
      tick(1);
      total++;
      if (bus.task_go !== '0) begin
         bad++;
         $display("FAIL single_go_width: got %h want 0000", bus.task_go);
      end
      man_done = 16'hFFFB;   // other tasks' done lines
      tick(1);
      man_done = '0;
      total++;
      if (bus.ack !== '0) begin
         bad++;
         $display("FAIL single_done_ignored: got ack=%h want 0000", bus.ack);
      end
      tick(3);
      man_done = 16'h0004;
      tick(1);
      man_done = '0;
      total++;
      if (bus.ack !== 16'h0004 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL single_ack_rise: got ack=%h busy=%b want 0004 1", bus.ack, bus.busy);
      end
      tick(1);
      total++;
      if (bus.ack !== 16'h0004) begin
         bad++;
         $display("FAIL single_ack_hold: got %h want 0004", bus.ack);
      end
      bus.req = '0;
      tick(1);
      total++;
      if (bus.ack !== '0 || bus.busy !== 1'b0 || bus.cur_task !== 4'd2) begin
         bad++;
         $display("FAIL single_ack_fall: got ack=%h busy=%b cur=%0d want 0000 0 2",
                  bus.ack, bus.busy, bus.cur_task);
      end
      total++;
      if (go_q.size() - go_base != 1 || ack_q.size() - ack_base != 1) begin
         bad++;
         $display("FAIL single_counts: got go=%0d ack=%0d want 1 1",
                  go_q.size() - go_base, ack_q.size() - ack_base);
      end
   endtask

   task automatic test_early_drop();
      int go_base;
      go_base = go_q.size();
      engine_auto = 1'b0;
      bus.req = 16'h0008;
      tick(2);
      total++;
      if (bus.task_go !== 16'h0008) begin
         bad++;
         $display("FAIL early_go: got %h want 0008", bus.task_go);
      end
      bus.req = '0;
      tick(3);
      man_done = 16'h0008;
      tick(1);
      man_done = '0;
      total++;
      if (bus.ack !== 16'h0008) begin
         bad++;
         $display("FAIL early_ack_rise: got %h want 0008", bus.ack);
      end
      tick(1);
      total++;
      if (bus.ack !== '0 || bus.busy !== 1'b0 || go_q.size() - go_base != 1) begin
         bad++;
         $display("FAIL early_ack_one_cycle: got ack=%h busy=%b go=%0d want 0000 0 1",
                  bus.ack, bus.busy, go_q.size() - go_base);
      end
   endtask

   task automatic test_priority();
      int go_base, ack_base, g0, g1, a0, a1;
      bit ok;
      go_base  = go_q.size();
      ack_base = ack_q.size();
      engine_auto  = 1'b1;
      engine_delay = 1;
      bus.req = 16'h8001;
      service(600, 1'b0, ok);
      g0 = (go_q.size()  > go_base)      ? go_q[go_base]        : -1;
      g1 = (go_q.size()  > go_base + 1)  ? go_q[go_base + 1]    : -1;
      a0 = (ack_q.size() > ack_base)     ? ack_q[ack_base]      : -1;
      a1 = (ack_q.size() > ack_base + 1) ? ack_q[ack_base + 1]  : -1;
      total++;
      if (!ok || go_q.size() - go_base != 2 || g0 != 0 || g1 != 15) begin
         bad++;
         $display("FAIL priority_go_order: got ok=%b n=%0d %0d,%0d want 1 2 0,15",
                  ok, go_q.size() - go_base, g0, g1);
      end
      total++;
      if (ack_q.size() - ack_base != 2 || a0 != 0 || a1 != 15) begin
         bad++;
         $display("FAIL priority_ack_order: got n=%0d %0d,%0d want 2 0,15",
                  ack_q.size() - ack_base, a0, a1);
      end
   endtask

   task automatic test_sweep();
      int go_base, got;
      bit ok;
      engine_auto  = 1'b1;
      engine_delay = 1;
      for (int i = 0; i < 16; i++) begin
         go_base = go_q.size();
         bus.req = 16'd1 << i;
         service(100, 1'b0, ok);
         got = (go_q.size() > go_base) ? go_q[go_base] : -1;
         total++;
         if (!ok || go_q.size() - go_base != 1 || got != i || bus.cur_task !== 4'(i)) begin
            bad++;
            $display("FAIL sweep_%0d: got ok=%b n=%0d go=%0d cur=%0d want 1 1 %0d %0d",
                     i, ok, go_q.size() - go_base, got, bus.cur_task, i, i);
         end
      end
   endtask

   task automatic test_random();
      int go_base, ack_base, exp_q[$];
      logic [15:0] mask;
      bit ok, early, mism;
      engine_auto = 1'b1;
      for (int b = 0; b < 20; b++) begin
         mask         = 16'($urandom_range(1, 65535));
         engine_delay = $urandom_range(1, 6);
         early        = 1'($urandom_range(0, 1));
         exp_q.delete();
         for (int i = 0; i < 16; i++) if (mask[i]) exp_q.push_back(i);
         go_base  = go_q.size();
         ack_base = ack_q.size();
         bus.req  = mask;
         service(600, early, ok);
         mism = !ok || (go_q.size() - go_base != exp_q.size())
                    || (ack_q.size() - ack_base != exp_q.size());
         if (!mism) begin
            for (int k = 0; k < exp_q.size(); k++) begin
               if (go_q[go_base + k] != exp_q[k] || ack_q[ack_base + k] != exp_q[k]) mism = 1'b1;
            end
         end
         total++;
         if (mism || bus.cur_task !== 4'(exp_q[exp_q.size() - 1])) begin
            bad++;
            $display("FAIL random_batch_%0d: mask=%h got n_go=%0d n_ack=%0d cur=%0d want n=%0d cur=%0d ascending",
                     b, mask, go_q.size() - go_base, ack_q.size() - ack_base,
                     bus.cur_task, exp_q.size(), exp_q[exp_q.size() - 1]);
         end
      end
      engine_auto = 1'b0;
   endtask

   task automatic test_mid_run_reset();
      int go_base;
      go_base = go_q.size();
      engine_auto = 1'b0;
      bus.req = 16'h0001;
      tick(2);
`ifdef TASK_DISPATCH_TIMEOUT_EN
      tick(5);
`else
      tick(50);
`endif
      total++;
      if (bus.ack !== '0 || bus.busy !== 1'b1 || bus.err !== 1'b0) begin
         bad++;
         $display("FAIL run_waits: got ack=%h busy=%b err=%b want 0000 1 0",
                  bus.ack, bus.busy, bus.err);
      end
      rst     = 1'b1;
      bus.req = '0;
      tick(1);
      rst = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.ack !== '0 || bus.cur_task !== 4'd0 || bus.task_go !== '0) begin
         bad++;
         $display("FAIL mid_run_reset: got busy=%b ack=%h cur=%0d go=%h want 0 0000 0 0000",
                  bus.busy, bus.ack, bus.cur_task, bus.task_go);
      end
      tick(5);
      total++;
      if (ack_q.size() != go_q.size() - 1 || go_q.size() - go_base != 1) begin
         bad++;
         $display("FAIL mid_run_no_ack: got go=%0d acks_total=%0d want go=1 acks=%0d",
                  go_q.size() - go_base, ack_q.size(), go_q.size() - 1);
      end
   endtask

`ifdef TASK_DISPATCH_TIMEOUT_EN
   task automatic test_timeout();
      int n, cnt;
      engine_auto = 1'b0;
      bus.req = 16'h0002;
      n = 0;
      while (bus.task_go == '0 && n < 10) begin
         tick(1);
         n++;
      end
      cnt = 0;
      while (bus.ack == '0 && cnt < 100) begin
         tick(1);
         cnt++;
      end
      total++;
      if (n >= 10 || cnt != 21 || bus.ack !== 16'h0002 || bus.err !== 1'b1) begin
         bad++;
         $display("FAIL timeout_ack: got go_wait=%0d cycles=%0d ack=%h err=%b want <10 21 0002 1",
                  n, cnt, bus.ack, bus.err);
      end
      bus.req = '0;
      tick(3);
      total++;
      if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin
         bad++;
         $display("FAIL timeout_sticky: got busy=%b err=%b want 0 1", bus.busy, bus.err);
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      total++;
      if (bus.err !== 1'b0) begin
         bad++;
         $display("FAIL timeout_err_clear: got %b want 0", bus.err);
      end
   endtask
`endif

   task automatic test_invariants();
      total++;
      if (n_multi_go != 0 || n_multi_ack != 0) begin
         bad++;
         $display("FAIL onehot: got multi_go=%0d multi_ack=%0d want 0 0", n_multi_go, n_multi_ack);
      end
   endtask

   initial begin
      bus.req = '0;
      test_reset();
      test_single();
      test_early_drop();
      test_priority();
      test_sweep();
      test_random();
      test_mid_run_reset();
`ifdef TASK_DISPATCH_TIMEOUT_EN
      test_timeout();
`endif
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/task_dispatch.md
Name: task_dispatch

Overview:
- Downstream consumer of the task register block: takes its 16 request bits, grants one task at a time, starts the matching task engine and returns a per-task four-phase acknowledge.
- Fixed priority, lowest index wins; one task in flight at a time.
- Gives firmware-written task bits a serialized, handshaken execution path.

Parameters:
- P_NTASK, 16, number of task lines; width of req/ack/task_go/task_done.
- P_TIMEOUT, 65535, watchdog limit in clk cycles; used only when TASK_DISPATCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  P_NTASK  task requests from task register; level, held until acked.
- ack  out  P_NTASK  per-task acknowledge to task register; four-phase.
- task_go  out  P_NTASK  one-hot, one-cycle start pulse to task engine.
- task_done  in  P_NTASK  per-task completion pulse or level from task engine.
- busy  out  1  high while a task is granted (GO through ACK).
- cur_task  out  4  index of granted or last-granted task.
- err  out  1  sticky timeout flag; constant 0 when the feature is compiled out.

Behaviour:
- All outputs registered. Reset values: ack=0, task_go=0, busy=0, cur_task=0, err=0, state=IDLE. Reset asserted in any state returns to IDLE on the next edge and abandons the task with no ack.
- States: IDLE, GO, RUN, ACK.
- IDLE -> GO: on the edge where req!=0. cur_task latches the lowest set index; busy=1.
- GO: task_go[cur_task]=1 for exactly one cycle, then RUN. This pulse is 2 cycles after req is first seen high in IDLE.
- RUN -> ACK: on the first edge with task_done[cur_task]=1. task_done is sampled only in RUN, so done during GO is ignored. task_done bits of other tasks are ignored in all states.
- ACK: ack[cur_task]=1. On the edge where req[cur_task]=0, ack returns to 0, busy=0, next state IDLE.
  - If req already dropped during RUN, ack is high for exactly one cycle.
- Ack bits are mutually exclusive; at most one ack bit is set.
- Requests arriving or dropping for other indices while busy do not disturb the current task. They are arbitrated on the next IDLE evaluation; IDLE with req!=0 re-grants with no idle gap.
- A request for cur_task that drops during GO/RUN does not abort the task; it completes and is acked.
- Simultaneous requests: lowest index first, the others serviced in ascending order on later passes. Higher indices can starve; this is acceptable.
- A task written again while still pending in req produces no extra run (level semantics).

Optional Feature:
- Macro: TASK_DISPATCH_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to RUN and increments each RUN cycle. When it reaches P_TIMEOUT without task_done[cur_task], the block goes to ACK as if done, and err is set. err is sticky until rst.
- Not defined: no counter; RUN waits indefinitely; err tied to 0.

Test Plan:
- Reset: hold rst 10 cycles -> ack=0, task_go=0, busy=0, cur_task=0, err=0; no go pulses.
- Single task: req=16'h0004; engine returns task_done[2] 5 cycles after task_go[2] -> one task_go=16'h0004 pulse, ack[2] rises 1 cycle after done, ack falls 1 cycle after req[2] drops.
- Priority: req=16'h8001 in one cycle -> task 0 runs and acks first, then task 15; task_go never has two bits set.
- Sweep all indices: write 1<<i for i=0..15 with an auto-responding engine (task_done=task_go delayed 1) -> 16 go pulses and 16 ack handshakes, cur_task tracks i.
- Early req drop: req[3] deasserted during RUN -> task still completes; ack[3] high exactly 1 cycle; back to IDLE.
- Timeout (TASK_DISPATCH_TIMEOUT_EN, P_TIMEOUT=20): req[1] with no done -> ack[1] rises 21 cycles after task_go[1], err=1 until rst. Mid-RUN rst -> IDLE, no ack.
